mul_issue_seq: RTL and testbench
================================

Name: mul_issue_seq

Overview:
- Sequencer directly upstream of the unsigned 64x64 Karatsuba multiplier in the RV64 integer datapath.
- Accepts RV64M multiply ops (MUL, MULH, MULHSU, MULHU, MULW) over a valid/ready handshake.
- Converts signed operands to magnitudes, launches the multiplier, and waits for its done.
- Applies sign correction to the 128-bit product, selects and formats the 64-bit result, and holds it until the consumer takes it.

Parameters:
- XLEN, 64, operand/result width; only 64 supported.
- DONE_MASK, 1, cycles after kmul_start during which kmul_done is ignored.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  op request
- in_ready  out  1  sequencer can accept an op (high only in IDLE)
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU; others behave as MULHU
- is_word  in  1  MULW (funct3 ignored)
- rs1  in  64  operand A
- rs2  in  64  operand B
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- result  out  64  formatted result
- busy  out  1  high in any state other than IDLE
- kmul_start  out  1  one-cycle start pulse to the multiplier
- kmul_a  out  64  magnitude of A, stable from the pulse until done
- kmul_b  out  64  magnitude of B, same rule
- kmul_done  in  1  multiplier finished
- kmul_s  in  128  unsigned product

Behaviour:
- Reset values: in_ready=1, out_valid=0, result=0, busy=0, kmul_start=0, kmul_a=0, kmul_b=0. FSM goes to IDLE.
- FSM: IDLE -> LAUNCH -> WAIT -> FIX -> RESP -> IDLE.
- IDLE:
  - An op is accepted when in_valid & in_ready.
  - Latch op, sign_a, sign_b and the magnitudes.
  - Signedness: MUL and MULH sign both operands; MULHSU signs A only; MULHU signs neither; MULW zero-extends rs1[31:0] and rs2[31:0] and is treated as unsigned.
  - Magnitude: if signed and negative, the two's complement; otherwise the raw value. 0x8000_0000_0000_0000 gives 2^63, which fits in 64 bits unsigned.
- LAUNCH: kmul_start=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - kmul_done is ignored for DONE_MASK cycles after the pulse, which rejects a stale done level.
  - After that, kmul_done=1 captures kmul_s and moves to FIX.
- FIX:
  - neg = sign_a ^ sign_b, and only when the corresponding operand is signed.
  - If neg, take the 128-bit two's complement of the product.
  - Select: MUL gives p[63:0]; MULH/MULHSU/MULHU give p[127:64]; MULW gives sign-extended p[31:0].
  - Register the result, set out_valid=1, go to RESP.
- RESP:
  - result and out_valid are held stable while out_ready=0.
  - On out_valid & out_ready: out_valid=0, go to IDLE. in_ready returns the following cycle, so no back-to-back accept.
- Latency from accept to out_valid: 1 (LAUNCH) + multiplier latency + 1 (FIX) cycles, minimum.
- Operand inputs and funct3 are don't-care outside the accept cycle.
- Reset mid-operation: immediate return to IDLE with all outputs at their reset values. The in-flight product is discarded. A kmul_done arriving later is ignored, because it is only sampled in WAIT.
- Inputs present while not in IDLE are ignored (in_ready=0).

Optional Feature:
- Macro: MUL_ZERO_BYPASS_EN.
- Defined:
  - If the latched A or B magnitude is 0 at accept, skip LAUNCH and WAIT: IDLE -> FIX with product forced to 0.
  - result=0, out_valid in the second cycle after accept.
  - kmul_start is never pulsed for such ops.
- Undefined: every op goes through the multiplier.

Test Plan:
- MUL rs1=3, rs2=0xFFFF_FFFF_FFFF_FFFB (-5) -> kmul_a=3, kmul_b=5, result=0xFFFF_FFFF_FFFF_FFF1.
- MULH rs1=rs2=0x8000_0000_0000_0000 -> result=0x4000_0000_0000_0000. MULHU with the same operands -> 0x4000_0000_0000_0000.
- MULHSU rs1=0xFFFF_FFFF_FFFF_FFFF, rs2=0xFFFF_FFFF_FFFF_FFFF -> result=0xFFFF_FFFF_FFFF_FFFF.
- MULW rs1=0x1234_5678_7FFF_FFFF, rs2=2 -> result=0xFFFF_FFFF_FFFF_FFFE.
- Backpressure: out_ready held 0 for 5 cycles -> result/out_valid stable; in_ready=0 and no kmul_start while in_valid=1. Release -> one transfer, then in_ready=1.
- rst_n pulsed low in WAIT, then kmul_done=1 after release -> out_valid stays 0, in_ready=1. The next op completes correctly. With MUL_ZERO_BYPASS_EN, MUL rs1=0 -> result=0 with no kmul_start.

Source files
------------

// File: rtl/mul_issue_if.sv
// Op request / result handshake between an issue stage and the multiply sequencer.
interface mul_issue_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      funct3;
  logic            is_word;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output in_valid, funct3, is_word, rs1, rs2, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, funct3, is_word, rs1, rs2, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/mul_issue_seq.sv
// RV64M multiply sequencer in front of the unsigned Karatsuba multiplier.
// Optional MUL_ZERO_BYPASS_EN: ops with a zero operand magnitude skip the multiplier.
//   state  | meaning
//   IDLE   | waiting for an op, in_ready high
//   LAUNCH | kmul_start pulse, magnitudes on kmul_a/kmul_b
//   WAIT   | masking stale done, then waiting for kmul_done
//   FIX    | sign-correct product and format result
//   RESP   | holding result until out_ready
module mul_issue_seq #(
  parameter int XLEN      = 64,
  parameter int DONE_MASK = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  mul_issue_if.slave        io,
  output logic              kmul_start,
  output logic [XLEN-1:0]   kmul_a,
  output logic [XLEN-1:0]   kmul_b,
  input  logic              kmul_done,
  input  logic [2*XLEN-1:0] kmul_s
);

  localparam int MW = (DONE_MASK > 0) ? $clog2(DONE_MASK + 1) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_FIX,
    ST_RESP
  } state_t;

  state_t            state;
  logic [2:0]        op_f3;
  logic              op_word;
  logic              neg;
  logic [MW-1:0]     mask_cnt;
  logic [2*XLEN-1:0] prod;
  logic              in_ready_q;
  logic              busy_q;
  logic              out_valid_q;
  logic [XLEN-1:0]   result_q;

  logic              sgn_a;
  logic              sgn_b;
  logic [XLEN-1:0]   opnd_a;
  logic [XLEN-1:0]   opnd_b;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic              zero_op;
  logic [2*XLEN-1:0] fixed;
  logic [XLEN-1:0]   sel;

  // sgn_* already folds in signedness: set only for a signed operand that is negative
  always_comb begin
    sgn_a  = 1'b0;
    sgn_b  = 1'b0;
    opnd_a = io.rs1;
    opnd_b = io.rs2;
    if (io.is_word) begin
      opnd_a = {{(XLEN-32){1'b0}}, io.rs1[31:0]};
      opnd_b = {{(XLEN-32){1'b0}}, io.rs2[31:0]};
    end else begin
      case (io.funct3)
        3'b000, 3'b001: begin
          sgn_a = io.rs1[XLEN-1];
          sgn_b = io.rs2[XLEN-1];
        end
        3'b010:  sgn_a = io.rs1[XLEN-1];
        default: ;
      endcase
    end
    mag_a = sgn_a ? -opnd_a : opnd_a;
    mag_b = sgn_b ? -opnd_b : opnd_b;
  end

`ifdef MUL_ZERO_BYPASS_EN
  assign zero_op = (mag_a == '0) || (mag_b == '0);
`else
  assign zero_op = 1'b0;
`endif

  always_comb begin
    fixed = neg ? -prod : prod;
    if (op_word) begin
      sel = {{(XLEN-32){fixed[31]}}, fixed[31:0]};
    end else if (op_f3 == 3'b000) begin
      sel = fixed[XLEN-1:0];
    end else begin
      sel = fixed[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      kmul_start  <= 1'b0;
      kmul_a      <= '0;
      kmul_b      <= '0;
      op_f3       <= '0;
      op_word     <= 1'b0;
      neg         <= 1'b0;
      mask_cnt    <= '0;
      prod        <= '0;
    end else begin
      kmul_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (io.in_valid) begin
            op_f3      <= io.funct3;
            op_word    <= io.is_word;
            neg        <= sgn_a ^ sgn_b;
            kmul_a     <= mag_a;
            kmul_b     <= mag_b;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (zero_op) begin
              prod  <= '0;
              state <= ST_FIX;
            end else begin
              kmul_start <= 1'b1;
              state      <= ST_LAUNCH;
            end
          end
        end
        ST_LAUNCH: begin
          mask_cnt <= MW'(DONE_MASK);
          state    <= ST_WAIT;
        end
        // a done level left over from the previous op must not be taken as this op's done
        ST_WAIT: begin
          if (mask_cnt != '0) begin
            mask_cnt <= mask_cnt - MW'(1);
          end else if (kmul_done) begin
            prod  <= kmul_s;
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          result_q    <= sel;
          out_valid_q <= 1'b1;
          state       <= ST_RESP;
        end
        ST_RESP: begin
          if (io.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.busy      = busy_q;
  assign io.out_valid = out_valid_q;
  assign io.result    = result_q;

endmodule

// File: tb/tb_mul_issue_seq.sv
// Random + directed bench for mul_issue_seq with a latency-randomised multiplier model.
module tb_mul_issue_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mul_issue_if #(.XLEN(64)) bus ();

  logic          kmul_start;
  logic [63:0]   kmul_a;
  logic [63:0]   kmul_b;
  logic          kmul_done = 1'b0;
  logic [127:0]  kmul_s = '0;

  mul_issue_seq #(.XLEN(64), .DONE_MASK(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .io         (bus.slave),
    .kmul_start (kmul_start),
    .kmul_a     (kmul_a),
    .kmul_b     (kmul_b),
    .kmul_done  (kmul_done),
    .kmul_s     (kmul_s)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: expected event did not occur", name);
  endtask

  // Reference: exact product of sign- or zero-extended operands, modulo 2^128
  function automatic logic [63:0] ref_res(input logic [2:0] f3, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [127:0] xa, xb, p;
    if (w) begin
      xa = {96'd0, a[31:0]};
      xb = {96'd0, b[31:0]};
    end else begin
      xa = (f3 <= 3'd2) ? {{64{a[63]}}, a} : {64'd0, a};
      xb = (f3 <= 3'd1) ? {{64{b[63]}}, b} : {64'd0, b};
    end
    p = xa * xb;
    if (w) return {{32{p[31]}}, p[31:0]};
    if (f3 == 3'd0) return p[63:0];
    return p[127:64];
  endfunction

  function automatic logic [63:0] mag(input logic [63:0] x, input bit sgn);
    return (sgn && x[63]) ? (64'd0 - x) : x;
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(7, 0))
      0:       return 64'd0;
      1:       return 64'd1;
      2:       return 64'hFFFF_FFFF_FFFF_FFFF;
      3:       return 64'h8000_0000_0000_0000;
      4:       return {32'd0, $urandom};
      5:       return {$urandom, 32'h8000_0000};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Multiplier model: done is a level that only drops a cycle after the next start
  int          m_cnt = 0;
  int          m_lat_force = 0;
  int          m_done_cnt = 0;
  logic [63:0] m_a = '0;
  logic [63:0] m_b = '0;

  always @(posedge clk) begin
    if (kmul_start) begin
      m_a   <= kmul_a;
      m_b   <= kmul_b;
      m_cnt <= (m_lat_force > 0) ? m_lat_force : int'($urandom_range(6, 2));
    end else if (m_cnt > 1) begin
      m_cnt     <= m_cnt - 1;
      kmul_done <= 1'b0;
    end else if (m_cnt == 1) begin
      m_cnt      <= 0;
      kmul_done  <= 1'b1;
      kmul_s     <= {64'd0, m_a} * {64'd0, m_b};
      m_done_cnt <= m_done_cnt + 1;
    end
  end

  typedef struct {
    logic [63:0] res;
    logic [63:0] ma;
    logic [63:0] mb;
    bit          zero;
    int          acc;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          op_starts = 0;
  int          start_mark = 0;
  logic [63:0] last_a = '0;
  logic [63:0] last_b = '0;
  bit          prev_ov = 0;
  bit          prev_or = 0;
  bit          prev_xfer = 0;
  logic [63:0] prev_res = '0;

  // q holds ops accepted at past edges and not yet handed over at past edges
  always @(negedge clk) begin
    exp_t        e;
    logic [63:0] xa, xb;
    bit          sa, sb;
    cyc++;
    if (!rst_n) begin
      q.delete();
      op_starts = 0;
      prev_ov   = 0;
      prev_or   = 0;
      prev_xfer = 0;
      check("rst_in_ready",   64'(bus.in_ready),   64'd1);
      check("rst_out_valid",  64'(bus.out_valid),  64'd0);
      check("rst_result",     bus.result,          64'd0);
      check("rst_busy",       64'(bus.busy),       64'd0);
      check("rst_kmul_start", 64'(kmul_start),     64'd0);
      check("rst_kmul_a",     kmul_a,              64'd0);
      check("rst_kmul_b",     kmul_b,              64'd0);
    end else begin
      check("in_ready", 64'(bus.in_ready), 64'(q.size() == 0));
      check("busy",     64'(bus.busy),     64'(q.size() != 0));
      if (prev_xfer) check("out_valid_drop", 64'(bus.out_valid), 64'd0);
      if (prev_ov && !prev_or) begin
        check("hold_valid",  64'(bus.out_valid), 64'd1);
        check("hold_result", bus.result, prev_res);
      end
      if (kmul_start) begin
        last_a = kmul_a;
        last_b = kmul_b;
        if (q.size() == 0) begin
          fail("start_while_idle");
        end else begin
          check("start_once", 64'(op_starts), 64'd0);
          check("kmul_a", kmul_a, q[0].ma);
          check("kmul_b", kmul_b, q[0].mb);
          op_starts++;
          start_mark = m_done_cnt;
        end
      end else if (q.size() != 0 && op_starts != 0) begin
        check("kmul_a_hold", kmul_a, q[0].ma);
        check("kmul_b_hold", kmul_b, q[0].mb);
      end
      prev_xfer = 0;
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          fail("spurious_out_valid");
        end else begin
          if (!prev_ov) begin
            check("result", bus.result, q[0].res);
            check("start_count", 64'(op_starts), q[0].zero ? 64'd0 : 64'd1);
            if (q[0].zero) check("bypass_latency", 64'(cyc - q[0].acc), 64'd2);
            else           check("fresh_done", 64'(m_done_cnt), 64'(start_mark + 1));
          end
          if (bus.out_ready) begin
            void'(q.pop_front());
            op_starts = 0;
            prev_xfer = 1;
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        if (bus.is_word) begin
          xa = {32'd0, bus.rs1[31:0]};
          xb = {32'd0, bus.rs2[31:0]};
          sa = 0;
          sb = 0;
        end else begin
          xa = bus.rs1;
          xb = bus.rs2;
          sa = (bus.funct3 <= 3'd2);
          sb = (bus.funct3 <= 3'd1);
        end
        e.ma  = mag(xa, sa);
        e.mb  = mag(xb, sb);
        e.res = ref_res(bus.funct3, bus.is_word, bus.rs1, bus.rs2);
        e.acc = cyc;
`ifdef MUL_ZERO_BYPASS_EN
        e.zero = (e.ma == 64'd0) || (e.mb == 64'd0);
`else
        e.zero = 0;
`endif
        q.push_back(e);
      end
      prev_ov  = bus.out_valid;
      prev_or  = bus.out_ready;
      prev_res = bus.result;
    end
  end

  // Caller and task both sit 2 time units after a rising edge on entry and return.
  task automatic run_op(input logic [2:0] f3, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input bit rnd, output logic [63:0] res);
    int n;
    bus.in_valid = 1'b1;
    bus.funct3   = f3;
    bus.is_word  = w;
    bus.rs1      = a;
    bus.rs2      = b;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 50);
    if (!bus.in_ready) fail("accept_timeout");
    @(posedge clk);
    #2;
    bus.in_valid = 1'b0;
    bus.funct3   = 3'($urandom_range(7, 0));
    bus.rs1      = {$urandom, $urandom};
    bus.rs2      = {$urandom, $urandom};
    res = '0;
    n = 0;
    forever begin
      bus.out_ready = rnd ? ($urandom_range(2, 0) != 0) : 1'b1;
      @(negedge clk);
      n++;
      if (bus.out_valid && bus.out_ready) begin
        res = bus.result;
        break;
      end
      if (n > 100) begin
        fail("result_timeout");
        break;
      end
      @(posedge clk);
      #2;
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r;
    logic [2:0]  f3;
    logic        w;
    int          n;
    bus.in_valid  = 1'b0;
    bus.funct3    = 3'd0;
    bus.is_word   = 1'b0;
    bus.rs1       = '0;
    bus.rs2       = '0;
    bus.out_ready = 1'b1;

    check("model_mul",    ref_res(3'd0, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB), 64'hFFFF_FFFF_FFFF_FFF1);
    check("model_mulh",   ref_res(3'd1, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000), 64'h4000_0000_0000_0000);
    check("model_mulhu",  ref_res(3'd3, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000), 64'h4000_0000_0000_0000);
    check("model_mulhsu", ref_res(3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF), 64'hFFFF_FFFF_FFFF_FFFF);
    check("model_mulw",   ref_res(3'd0, 1'b1, 64'h1234_5678_7FFF_FFFF, 64'd2), 64'hFFFF_FFFF_FFFF_FFFE);

    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    run_op(3'd0, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0, r);
    check("mul_neg", r, 64'hFFFF_FFFF_FFFF_FFF1);
    check("mul_neg_kmul_a", last_a, 64'd3);
    check("mul_neg_kmul_b", last_b, 64'd5);
    run_op(3'd1, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, r);
    check("mulh_min", r, 64'h4000_0000_0000_0000);
    check("mulh_min_kmul_a", last_a, 64'h8000_0000_0000_0000);
    run_op(3'd3, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, r);
    check("mulhu_min", r, 64'h4000_0000_0000_0000);
    run_op(3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, r);
    check("mulhsu_ones", r, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op(3'd0, 1'b1, 64'h1234_5678_7FFF_FFFF, 64'd2, 1'b0, r);
    check("mulw_ovf", r, 64'hFFFF_FFFF_FFFF_FFFE);

    // backpressure with a second op waiting on the input side
    bus.in_valid  = 1'b1;
    bus.funct3    = 3'd3;
    bus.is_word   = 1'b0;
    bus.rs1       = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.rs2       = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.out_ready = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 50);
    @(posedge clk);
    #2;
    bus.funct3 = 3'd0;
    bus.rs1    = 64'd5;
    bus.rs2    = 64'd7;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 100);
    if (!bus.out_valid) fail("bp_timeout");
    repeat (5) begin
      @(negedge clk);
      check("bp_valid",    64'(bus.out_valid), 64'd1);
      check("bp_result",   bus.result, 64'hFFFF_FFFF_FFFF_FFFE);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      check("bp_no_start", 64'(kmul_start), 64'd0);
    end
    @(posedge clk);
    #2;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    @(posedge clk);
    #2;
    @(negedge clk);
    check("bp_in_ready_back", 64'(bus.in_ready), 64'd1);
    check("bp_valid_drop",    64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #2;

    // reset while waiting on the multiplier; its late done must be ignored
    m_lat_force  = 8;
    bus.in_valid = 1'b1;
    bus.funct3   = 3'd0;
    bus.is_word  = 1'b0;
    bus.rs1      = 64'd11;
    bus.rs2      = 64'd13;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!kmul_start && n < 20);
    if (!kmul_start) fail("rst_launch_timeout");
    @(posedge clk);
    #2;
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      check("rst_no_valid", 64'(bus.out_valid), 64'd0);
      check("rst_ready",    64'(bus.in_ready),  64'd1);
    end
    m_lat_force = 0;
    @(posedge clk);
    #2;
    run_op(3'd0, 1'b0, 64'd6, 64'd7, 1'b0, r);
    check("after_rst_mul", r, 64'd42);

`ifdef MUL_ZERO_BYPASS_EN
    run_op(3'd0, 1'b0, 64'd0, 64'd5, 1'b0, r);
    check("bypass_zero", r, 64'd0);
`endif

    for (int i = 0; i < 150; i++) begin
      f3 = 3'($urandom_range(7, 0));
      w  = ($urandom_range(4, 0) == 0);
      run_op(f3, w, pick(), pick(), 1'b1, r);
    end

    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
